// File: rtl/apple_spawn_ctrl.sv
// Apple placement sequencer for the 16x16 LED snake board: random candidate search, apple latch, score/win tracking.
// Build option APPLE_SCAN_FALLBACK_EN adds a linear board scan after MAX_TRIES rejected random candidates.
module apple_spawn_ctrl #(
   parameter int MAX_TRIES = 8,
   parameter int SCORE_MAX = 63
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                eat,
   input  logic [3:0]          rnd_row,
   input  logic [3:0]          rnd_col,
   input  logic [15:0][15:0]   snake_pixels,
   output logic                lfsr_en,
   output logic                apple_valid,
   output logic [3:0]          apple_row,
   output logic [3:0]          apple_col,
   output logic [15:0][15:0]   red_pixels,
   output logic [5:0]          score,
   output logic                game_won,
   output logic                board_full
);

   // state | meaning
   // SEEK  | step both LFSRs for a fresh candidate
   // CHECK | test candidate against snake body
   // HOLD  | apple placed, waiting for eat
   // DONE  | game over (won or board full), frozen until reset
   // SCAN  | linear fallback search over all cells (fallback build only)
`ifdef APPLE_SCAN_FALLBACK_EN
   typedef enum logic [2:0] {SEEK, CHECK, HOLD, DONE, SCAN} state_t;
`else
   typedef enum logic [2:0] {SEEK, CHECK, HOLD, DONE} state_t;
`endif

   localparam logic [4:0] TRY_LIM   = 5'(MAX_TRIES);
   localparam logic [5:0] SCORE_LIM = 6'(SCORE_MAX);

   state_t              state, state_n;
   logic [3:0]          tries, tries_n;
   logic                valid_n;
   logic [3:0]          row_n, col_n;
   logic [15:0][15:0]   red_n;
   logic [5:0]          score_n;
   logic                won_n;
`ifdef APPLE_SCAN_FALLBACK_EN
   logic [7:0]          scan_idx, scan_idx_n;
   logic                full_q, full_n;
`endif

   assign lfsr_en = (state == SEEK);

   always_comb begin
      state_n = state;
      tries_n = tries;
      valid_n = apple_valid;
      row_n   = apple_row;
      col_n   = apple_col;
      red_n   = red_pixels;
      score_n = score;
      won_n   = game_won;
`ifdef APPLE_SCAN_FALLBACK_EN
      scan_idx_n = scan_idx;
      full_n     = full_q;
`endif
      case (state)
         SEEK: state_n = CHECK;
         CHECK: begin
            if (!snake_pixels[rnd_row][rnd_col]) begin
               row_n   = rnd_row;
               col_n   = rnd_col;
               valid_n = 1'b1;
               red_n   = '0;
               red_n[rnd_row][rnd_col] = 1'b1;
               tries_n = 4'd0;
               state_n = HOLD;
            end else if (({1'b0, tries} + 5'd1) == TRY_LIM) begin
`ifdef APPLE_SCAN_FALLBACK_EN
               tries_n    = tries + 4'd1;
               scan_idx_n = 8'd0;
               state_n    = SCAN;
`else
               tries_n = 4'd0;
               state_n = SEEK;
`endif
            end else begin
               tries_n = tries + 4'd1;
               state_n = SEEK;
            end
         end
         HOLD: begin
            if (eat) begin
               score_n = score + 6'd1;
               valid_n = 1'b0;
               red_n   = '0;
               if (score_n == SCORE_LIM) begin
                  won_n   = 1'b1;
                  state_n = DONE;
               end else begin
                  state_n = SEEK;
               end
            end
         end
`ifdef APPLE_SCAN_FALLBACK_EN
         SCAN: begin
            if (!snake_pixels[scan_idx[7:4]][scan_idx[3:0]]) begin
               row_n      = scan_idx[7:4];
               col_n      = scan_idx[3:0];
               valid_n    = 1'b1;
               red_n      = '0;
               red_n[scan_idx[7:4]][scan_idx[3:0]] = 1'b1;
               tries_n    = 4'd0;
               scan_idx_n = 8'd0;
               state_n    = HOLD;
            end else if (scan_idx == 8'hFF) begin
               full_n  = 1'b1;
               state_n = DONE;
            end else begin
               scan_idx_n = scan_idx + 8'd1;
            end
         end
`endif
         default: state_n = state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= SEEK;
         tries       <= 4'd0;
         apple_valid <= 1'b0;
         apple_row   <= 4'd0;
         apple_col   <= 4'd0;
         red_pixels  <= '0;
         score       <= 6'd0;
         game_won    <= 1'b0;
`ifdef APPLE_SCAN_FALLBACK_EN
         scan_idx    <= 8'd0;
         full_q      <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         tries       <= tries_n;
         apple_valid <= valid_n;
         apple_row   <= row_n;
         apple_col   <= col_n;
         red_pixels  <= red_n;
         score       <= score_n;
         game_won    <= won_n;
`ifdef APPLE_SCAN_FALLBACK_EN
         scan_idx    <= scan_idx_n;
         full_q      <= full_n;
`endif
      end
   end

`ifdef APPLE_SCAN_FALLBACK_EN
   assign board_full = full_q;
`else
   assign board_full = 1'b0;
`endif

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Bench for apple_spawn_ctrl: behavioural game model checked every cycle, plus directed literal checks.
// Honours APPLE_SCAN_FALLBACK_EN to exercise the scan fallback when built with it.
module tb_apple_spawn_ctrl;
   localparam int MT = 8;
   localparam int SM = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              eat = 1'b0;
   logic [3:0]        rnd_row = 4'd0;
   logic [3:0]        rnd_col = 4'd0;
   logic [15:0][15:0] snake = '0;
   logic              lfsr_en, apple_valid, game_won, board_full;
   logic [3:0]        apple_row, apple_col;
   logic [15:0][15:0] red_pixels;
   logic [5:0]        score;

   apple_spawn_ctrl #(.MAX_TRIES(MT), .SCORE_MAX(SM)) dut (
      .clk(clk), .reset(reset), .eat(eat), .rnd_row(rnd_row), .rnd_col(rnd_col),
      .snake_pixels(snake), .lfsr_en(lfsr_en), .apple_valid(apple_valid),
      .apple_row(apple_row), .apple_col(apple_col), .red_pixels(red_pixels),
      .score(score), .game_won(game_won), .board_full(board_full));

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Stand-in for the LFSR pair: each enabled step presents the next queued candidate.
   logic [7:0] cand[$];
   int pulses = 0;
   always @(posedge clk) begin
      if (!reset && lfsr_en) begin
         pulses++;
         if (cand.size() > 0) {rnd_row, rnd_col} <= cand.pop_front();
      end
   end

   // Game model: phase 0 step, 1 test candidate, 2 apple up, 3 game over, 4 scanning.
   int ph = 0, tries = 0, sidx = 0, msc = 0;
   logic mv = 1'b0, mwon = 1'b0, mfull = 1'b0;
   logic [3:0] mr = 4'd0, mc = 4'd0;
   bit started = 1'b0;

   task automatic mplace(input logic [3:0] r, input logic [3:0] c);
      mr = r; mc = c; mv = 1'b1; tries = 0; ph = 2;
   endtask

   always @(posedge clk) begin
      started = 1'b1;
      if (reset) begin
         ph = 0; tries = 0; sidx = 0; msc = 0;
         mv = 1'b0; mwon = 1'b0; mfull = 1'b0; mr = 4'd0; mc = 4'd0;
      end else begin
         case (ph)
            0: ph = 1;
            1: begin
               if (!snake[rnd_row][rnd_col]) mplace(rnd_row, rnd_col);
               else begin
                  tries++;
                  if (tries == MT) begin
`ifdef APPLE_SCAN_FALLBACK_EN
                     ph = 4; sidx = 0;
`else
                     tries = 0; ph = 0;
`endif
                  end else ph = 0;
               end
            end
            2: if (eat) begin
               msc++; mv = 1'b0;
               if (msc == SM) begin mwon = 1'b1; ph = 3; end
               else ph = 0;
            end
            4: begin
               if (!snake[sidx / 16][sidx % 16]) begin
                  mplace(4'(sidx / 16), 4'(sidx % 16));
                  sidx = 0;
               end else if (sidx == 255) begin
                  mfull = 1'b1; ph = 3;
               end else sidx++;
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("lfsr_en", lfsr_en, (ph == 0));
         chk("apple_valid", apple_valid, mv);
         chk("apple_row", apple_row, mr);
         chk("apple_col", apple_col, mc);
         chk("red_pixels", red_pixels, mv ? (256'd1 << (mr * 16 + mc)) : 256'd0);
         chk("score", score, msc);
         chk("game_won", game_won, mwon);
         chk("board_full", board_full, mfull);
      end
   end

   task automatic pulse_eat();
      eat = 1'b1;
      @(negedge clk);
      eat = 1'b0;
   endtask

   task automatic wait_valid(input int budget, input string name, output int n);
      n = 0;
      while (!apple_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!apple_valid) begin
         bad++;
         $display("FAIL %s: apple_valid still 0 after %0d cycles, want 1", name, n);
      end
   endtask

   int n;

   initial begin
      repeat (2) @(negedge clk);
      // 1: first apple two cycles after reset
      cand.push_back(8'h35);
      reset = 1'b0;
      wait_valid(10, "t1_wait", n);
      chk("t1_latency", n, 2);
      chk("t1_row", apple_row, 4'd3);
      chk("t1_col", apple_col, 4'd5);
      chk("t1_red", red_pixels, 256'd1 << 53);
      chk("t1_score", score, 6'd0);

      // 2: eat clears apple next cycle, then respawn
      cand.push_back(8'h72);
      pulse_eat();
      chk("t2_valid_clr", apple_valid, 1'b0);
      chk("t2_score", score, 6'd1);
      wait_valid(10, "t2_wait", n);
      chk("t2_latency", n, 2);
      chk("t2_row", apple_row, 4'd7);
      chk("t2_col", apple_col, 4'd2);

      // 3: three occupied candidates then a free one
      snake[1][1] = 1'b1; snake[2][2] = 1'b1; snake[4][4] = 1'b1;
      cand.push_back(8'h11); cand.push_back(8'h22); cand.push_back(8'h44); cand.push_back(8'h99);
      pulses = 0;
      pulse_eat();
      wait_valid(30, "t3_wait", n);
      chk("t3_pulses", pulses, 4);
      chk("t3_row", apple_row, 4'd9);
      chk("t3_col", apple_col, 4'd9);

      // 5: third eat reaches SCORE_MAX; further eat ignored
      snake = '0;
      pulse_eat();
      chk("t5_score", score, 6'd3);
      chk("t5_won", game_won, 1'b1);
      repeat (2) @(negedge clk);
      chk("t5_lfsr_off", lfsr_en, 1'b0);
      pulse_eat();
      chk("t5_score_hold", score, 6'd3);
      chk("t5_won_hold", game_won, 1'b1);

      // 6a: reset in CHECK
      reset = 1'b1;
      @(negedge clk);
      cand.push_back(8'h3c);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("t6a_valid", apple_valid, 1'b0);
      chk("t6a_red", red_pixels, 256'd0);
      chk("t6a_score", score, 6'd0);
      chk("t6a_lfsr", lfsr_en, 1'b1);

`ifdef APPLE_SCAN_FALLBACK_EN
      // 4: random tries exhausted, scan finds (15,0); then full board
      snake = '1;
      snake[15][0] = 1'b0;
      reset = 1'b0;
      wait_valid(2 * MT + 256 + 8, "t4_wait", n);
      chk("t4_latency", n, 2 * MT + 241);
      chk("t4_row", apple_row, 4'd15);
      chk("t4_col", apple_col, 4'd0);
      snake = '1;
      pulse_eat();
      n = 0;
      while (!board_full && n < 2 * MT + 256 + 8) begin
         @(negedge clk);
         n++;
      end
      chk("t4_full", board_full, 1'b1);
      chk("t4_full_valid", apple_valid, 1'b0);
      chk("t4_full_lfsr", lfsr_en, 1'b0);

      // 6b: reset while scanning
      reset = 1'b1;
      @(negedge clk);
      snake = '1;
      snake[15][0] = 1'b0;
      reset = 1'b0;
      repeat (2 * MT + 5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("t6b_full", board_full, 1'b0);
      chk("t6b_valid", apple_valid, 1'b0);
      chk("t6b_lfsr", lfsr_en, 1'b1);
      reset = 1'b0;
      repeat (3) @(negedge clk);
`else
      // 4: without fallback, random retry continues past MAX_TRIES
      snake = '0;
      snake[0][0] = 1'b1;
      for (int i = 0; i < 10; i++) cand.push_back(8'h00);
      cand.push_back(8'h66);
      reset = 1'b0;
      wait_valid(60, "t4_wait", n);
      chk("t4_latency", n, 22);
      chk("t4_row", apple_row, 4'd6);
      chk("t4_col", apple_col, 4'd6);
      chk("t4_full", board_full, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end
endmodule
